// File: rtl/gray_wptr_full.sv
// gray_wptr_full: async FIFO write-side Gray pointer and full flag; ports clk_i rst_i push_i rgray_sync_i -> waddr_o wen_o wgray_o full_o (+almost_full_o when WPTR_ALMOST_FULL_EN)
module gray_wptr_full #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH = 2**ADDR_WIDTH-1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH:0]   rgray_sync_i,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic                  wen_o,
  output logic [ADDR_WIDTH:0]   wgray_o,
  output logic                  full_o
`ifdef WPTR_ALMOST_FULL_EN
  ,
  output logic                  almost_full_o
`endif
);
  localparam logic [ADDR_WIDTH:0] flip = (ADDR_WIDTH+1)'(3) << (ADDR_WIDTH-1);
  logic [ADDR_WIDTH:0] wbin, wbin_next, wgray_next;
  if (AF_THRESH < 1 || AF_THRESH > 2**ADDR_WIDTH) begin : g_bad_thresh
    $error("AF_THRESH out of range");
  end
  assign wen_o = push_i & ~full_o;
  assign wbin_next = wbin + (ADDR_WIDTH+1)'(wen_o);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign waddr_o = wbin[ADDR_WIDTH-1:0];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wbin <= '0;
      wgray_o <= '0;
      full_o <= 1'b0;
    end else begin
      wbin <= wbin_next;
      wgray_o <= wgray_next;
      full_o <= wgray_next == (rgray_sync_i ^ flip);
    end
  end
`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [ADDR_WIDTH:0] af_thr = (ADDR_WIDTH+1)'(AF_THRESH);
  logic [ADDR_WIDTH:0] rbin, level;
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) rbin[i] = ^(rgray_sync_i >> i);
  end
  assign level = wbin_next - rbin;
  always_ff @(posedge clk_i) almost_full_o <= rst_i ? 1'b0 : level >= af_thr;
`endif
endmodule

// File: tb/tb_gray_wptr_full.sv
module tb_gray_wptr_full;
  localparam int AW = 2;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic push_i = 1'b0;
  logic [AW:0] rgray_sync_i = '0;
  logic [AW-1:0] waddr_o;
  logic wen_o;
  logic [AW:0] wgray_o;
  logic full_o;
  logic almost_full_o;
  int checks = 0;
  int failures = 0;
  int wc, rc;
  bit mfull, maf;
  logic [2:0] gtab [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
  typedef struct {
    bit push;
    logic [2:0] rg;
    bit wen;
    logic [2:0] wg;
    logic [1:0] wa;
    bit full;
  } vec_t;
  vec_t tbl [10];

  gray_wptr_full #(.ADDR_WIDTH(AW), .AF_THRESH(3)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(push_i),
    .rgray_sync_i(rgray_sync_i),
    .waddr_o(waddr_o),
    .wen_o(wen_o),
    .wgray_o(wgray_o),
    .full_o(full_o)
`ifdef WPTR_ALMOST_FULL_EN
    ,
    .almost_full_o(almost_full_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    push_i = 1'b1;
    rgray_sync_i = '0;
    repeat (n) begin
      @(posedge clk_i);
      #1;
      chk("rst_wgray", 32'(wgray_o), 0);
      chk("rst_waddr", 32'(waddr_o), 0);
      chk("rst_full", 32'(full_o), 0);
`ifdef WPTR_ALMOST_FULL_EN
      chk("rst_af", 32'(almost_full_o), 0);
`endif
    end
    rst_i = 1'b0;
    push_i = 1'b0;
    wc = 0;
    rc = 0;
    mfull = 1'b0;
    maf = 1'b0;
  endtask

  // Reference: pointers are plain occupancy counts; Gray codes come from a lookup table.
  task automatic step(input bit p, input int r);
    logic [2:0] prev;
    bit ew;
    push_i = p;
    rc = r;
    rgray_sync_i = gtab[r & 7];
    prev = wgray_o;
    #1;
    ew = p && !mfull;
    chk("wen", 32'(wen_o), 32'(ew));
    if (ew) wc++;
    mfull = ((wc - rc) & 7) == 4;
    maf = ((wc - rc) & 7) >= 3;
    @(posedge clk_i);
    #1;
    chk("wgray", 32'(wgray_o), 32'(gtab[wc & 7]));
    chk("waddr", 32'(waddr_o), 32'(wc & 3));
    chk("full", 32'(full_o), 32'(mfull));
    chk("gray_step_bits", 32'($countones(prev ^ wgray_o)), ew ? 1 : 0);
`ifdef WPTR_ALMOST_FULL_EN
    chk("almost_full", 32'(almost_full_o), 32'(maf));
`endif
  endtask

  initial begin
    tbl[0] = '{1'b1, 3'b000, 1'b1, 3'b001, 2'd1, 1'b0};
    tbl[1] = '{1'b1, 3'b000, 1'b1, 3'b011, 2'd2, 1'b0};
    tbl[2] = '{1'b1, 3'b000, 1'b1, 3'b010, 2'd3, 1'b0};
    tbl[3] = '{1'b1, 3'b000, 1'b1, 3'b110, 2'd0, 1'b1};
    tbl[4] = '{1'b1, 3'b000, 1'b0, 3'b110, 2'd0, 1'b1};
    tbl[5] = '{1'b1, 3'b000, 1'b0, 3'b110, 2'd0, 1'b1};
    tbl[6] = '{1'b1, 3'b000, 1'b0, 3'b110, 2'd0, 1'b1};
    tbl[7] = '{1'b0, 3'b001, 1'b0, 3'b110, 2'd0, 1'b0};
    tbl[8] = '{1'b1, 3'b001, 1'b1, 3'b111, 2'd1, 1'b1};
    tbl[9] = '{1'b1, 3'b001, 1'b0, 3'b111, 2'd1, 1'b1};
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      push_i = tbl[i].push;
      rgray_sync_i = tbl[i].rg;
      #1;
      chk($sformatf("tbl%0d_wen", i), 32'(wen_o), 32'(tbl[i].wen));
      @(posedge clk_i);
      #1;
      chk($sformatf("tbl%0d_wgray", i), 32'(wgray_o), 32'(tbl[i].wg));
      chk($sformatf("tbl%0d_waddr", i), 32'(waddr_o), 32'(tbl[i].wa));
      chk($sformatf("tbl%0d_full", i), 32'(full_o), 32'(tbl[i].full));
    end
    do_reset(1);
    for (int i = 0; i < 10; i++) step(1'b1, wc >= 2 ? wc - 2 : 0);
    chk("wrap_wgray", 32'(wgray_o), 32'(3'b011));
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b1, 0);
    step(1'b0, 1);
    step(1'b1, 1);
    step(1'b1, 3);
`ifdef WPTR_ALMOST_FULL_EN
    do_reset(1);
    repeat (3) step(1'b1, 0);
    chk("af3_af", 32'(almost_full_o), 1);
    chk("af3_wgray", 32'(wgray_o), 32'(3'b010));
    chk("af3_full", 32'(full_o), 0);
    step(1'b1, 0);
    chk("af4_af", 32'(almost_full_o), 1);
    chk("af4_full", 32'(full_o), 1);
`endif
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      int r;
      r = rc;
      if (r < wc && $urandom_range(0, 1) == 1) r++;
      step($urandom_range(0, 3) != 0, r);
      if (i == 300) do_reset(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
